// File: rtl/fsk_dds_loader.sv
// Feeds the single-CS SPI master that drives the FSK DDS. It sends the DDS init sequence,
// then turns FSK symbols into FSELECT control-word writes, two bytes per word, MSB first.
module fsk_dds_loader #(
    parameter logic [27:0] FREQ0_WORD = 28'h0A7C5AC,
    parameter logic [27:0] FREQ1_WORD = 28'h1000000,
    parameter logic [15:0] CTRL_RUN   = 16'h2000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Symbol,
    input  logic       i_Symbol_Valid,
    output logic       o_Symbol_Ready,
    output logic       o_Init_Done,
    output logic       o_Fsel,
    output logic [7:0] o_TX_Byte,
    output logic       o_TX_Valid,
    input  logic       i_TX_Ready,
    output logic       o_SPI_Start,
    output logic       o_SPI_Stop
);

    typedef enum logic [3:0] {
        OFF, ARM, LOAD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, RUN, STOP
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [15:0] word, word_nxt;
    logic        run_sym, run_sym_nxt;
    logic [7:0]  tx_byte_nxt;
    logic        tx_valid_nxt, start_nxt, stop_nxt, done_nxt, fsel_nxt;

    function automatic logic [15:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    return 16'h2100;
            3'd1:    return {2'b01, FREQ0_WORD[13:0]};
            3'd2:    return {2'b01, FREQ0_WORD[27:14]};
            3'd3:    return {2'b10, FREQ1_WORD[13:0]};
            3'd4:    return {2'b10, FREQ1_WORD[27:14]};
            3'd5:    return 16'hC000;
            default: return CTRL_RUN;
        endcase
    endfunction

    assign o_Symbol_Ready = i_Enable & (state == RUN);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= OFF;
            idx         <= 3'd0;
            word        <= 16'h0000;
            run_sym     <= 1'b0;
            o_TX_Byte   <= 8'h00;
            o_TX_Valid  <= 1'b0;
            o_SPI_Start <= 1'b0;
            o_SPI_Stop  <= 1'b0;
            o_Init_Done <= 1'b0;
            o_Fsel      <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            word        <= word_nxt;
            run_sym     <= run_sym_nxt;
            o_TX_Byte   <= tx_byte_nxt;
            o_TX_Valid  <= tx_valid_nxt;
            o_SPI_Start <= start_nxt;
            o_SPI_Stop  <= stop_nxt;
            o_Init_Done <= done_nxt;
            o_Fsel      <= fsel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        word_nxt     = word;
        run_sym_nxt  = run_sym;
        tx_byte_nxt  = o_TX_Byte;
        tx_valid_nxt = 1'b0;
        start_nxt    = 1'b0;
        stop_nxt     = 1'b0;
        done_nxt     = o_Init_Done;
        fsel_nxt     = o_Fsel;
        case (state)
            OFF: begin
                if (i_Enable) begin
                    start_nxt = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                idx_nxt   = 3'd0;
                state_nxt = i_Enable ? LOAD : STOP;
            end
            LOAD: begin
                word_nxt  = o_Init_Done ? (CTRL_RUN | {4'b0000, run_sym, 11'b0})
                                        : init_word(idx);
                state_nxt = SEND_HI;
            end
            SEND_HI: begin
                if (i_TX_Ready) begin
                    tx_byte_nxt  = word[15:8];
                    tx_valid_nxt = 1'b1;
                    state_nxt    = WAIT_HI;
                end
            end
            // o_TX_Valid is high exactly in the first WAIT cycle, so it doubles as the guard
            WAIT_HI: begin
                if (!o_TX_Valid && i_TX_Ready) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                if (i_TX_Ready) begin
                    tx_byte_nxt  = word[7:0];
                    tx_valid_nxt = 1'b1;
                    state_nxt    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!o_TX_Valid && i_TX_Ready) begin
                    if (o_Init_Done) begin
                        fsel_nxt  = run_sym;
                        state_nxt = i_Enable ? RUN : STOP;
                    end else if (!i_Enable) begin
                        state_nxt = STOP;
                    end else if (idx == 3'd6) begin
                        fsel_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = LOAD;
                    end
                end
            end
            RUN: begin
                if (!i_Enable) begin
                    state_nxt = STOP;
                end else if (i_Symbol_Valid && (i_Symbol != o_Fsel)) begin
                    run_sym_nxt = i_Symbol;
                    state_nxt   = LOAD;
                end
            end
            STOP: begin
                if (i_TX_Ready) begin
                    stop_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    state_nxt = OFF;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

endmodule
